time_set_ctrl: RTL
==================

# time_set_ctrl

Run/set controller for the HH:MM:SS BCD time counter chain. It divides the system clock into the one-second advance enable that drives the seconds digit-0 counter. It also runs the user time-setting state machine from two debounced buttons, edits hour and minute BCD digits, and issues a one-cycle load command that writes the edited time into the counter chain with seconds cleared.

## Interface

Parameters:
- TICK_DIV, default 100_000_000: system-clock cycles per one-second advance; legal range ≥ 2. The internal prescaler width is $clog2(TICK_DIV).

Ports:
- clk  in  1  global clock, rising edge
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  debounced mode button, level, high = pressed
- btn_inc  in  1  debounced increment button, level, high = pressed
- cur_hour1, cur_hour0  in  4 each  current hour digits from the counter chain, valid BCD, 00–23
- cur_min1, cur_min0  in  4 each  current minute digits from the counter chain, valid BCD, 00–59
- cnt_en  out  1  one-cycle advance pulse to the seconds counter
- load  out  1  one-cycle pulse; the counter chain loads the set_* digits and clears seconds to 00
- set_hour1, set_hour0, set_min1, set_min0  out  4 each  edited time digits
- mode  out  2  current mode: 2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN
- blink  out  1  display blink for the digit pair being edited

## Operation

Button edge detect:
- Each button has a registered previous level.
- press = btn & ~prev.
- prev resets to 1, so a button held through reset release must be released before it registers a press.
- Holding a button produces exactly one press.

State machine. States are RUN, SET_HOUR and SET_MIN; all transitions are registered.
- RUN + mode press → SET_HOUR. On the same edge, capture cur_hour1/0 and cur_min1/0 into the set_* registers.
- SET_HOUR + inc press → hour = hour + 1 in BCD (x9 → (x+1)0); 23 wraps to 00. Minutes unchanged.
- SET_HOUR + mode press → SET_MIN.
- SET_MIN + inc press → minute = minute + 1 in BCD; 59 wraps to 00. Hours unchanged.
- SET_MIN + mode press → RUN, and load is driven high for the next cycle.
- Simultaneous mode and inc press: mode wins; the increment is discarded.
- btn_inc in RUN is ignored.

Prescaler:
- Counts 0..TICK_DIV-1 only in RUN.
- When it reaches TICK_DIV-1, it returns to 0 and cnt_en is registered high for one cycle.
- It is held at 0 in SET_HOUR and SET_MIN. cnt_en is therefore 0 throughout setting, so time is frozen.
- On return to RUN the prescaler restarts from 0.

Blink:
- In the SET states, a separate blink divider toggles blink every TICK_DIV cycles.
- Entering SET_HOUR starts blink at 1.
- blink is forced to 0 in RUN.

Reset value of every output (asynchronous):
- mode = 00 (RUN)
- set_* = 0
- cnt_en = 0
- load = 0
- blink = 0
- prescaler = 0
- Reset during SET_* abandons the edit; no load pulse is issued.

## Timing

- Edge-to-state latency: a press sampled at edge N changes mode after edge N.
  - Capture and increment results are visible on set_* after edge N.
  - load is high during the cycle between edges N and N+1, with set_* stable and valid in that cycle.
- First cnt_en after reset deassertion is high following the TICK_DIV-th rising edge, for exactly one cycle. Afterwards the period is exactly TICK_DIV cycles.
- After the RUN re-entry edge N, the next cnt_en follows edge N+TICK_DIV.
- cnt_en and load are never high in the same cycle.
- cur_* inputs are sampled only on the RUN→SET_HOUR edge. Their changes at any other time have no effect.

## Test plan

All scenarios use TICK_DIV=4.

- **Reset and free run:** assert rst, release, buttons idle.
  - Required: mode=00, load=0, blink=0.
  - cnt_en pulses one cycle after edges 4, 8 and 12, and no others.
- **Enter set mode:** cur=12:34, one btn_mode press.
  - Required: mode=01; set_hour1/0=1/2; set_min1/0=3/4.
  - cnt_en stays 0 for 20 cycles; blink starts at 1 and toggles every 4 cycles.
- **Hour edit and wrap:** in SET_HOUR from 22, two inc presses, then btn_inc held high for 10 cycles.
  - Required: set_hour becomes 23, then 00.
  - The held button produces one more step only (01), not repeated increments.
- **Minute edit and wrap:** mode press to SET_MIN with minutes at 58, two inc presses.
  - Required: set_min becomes 59, then 00; set_hour unchanged.
- **Commit:** mode press in SET_MIN with set=01:00.
  - Required: mode=00, load high exactly one cycle with set_*=0,1,0,0.
  - The first cnt_en follows the 4th edge after the transition edge.
- **Simultaneous press and mid-edit reset:**
  - In SET_HOUR, press mode and inc on the same edge. Required: mode=10, hour unchanged.
  - Then assert rst. Required: mode=00, set_*=0, load never asserted, blink=0.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Run/set controller for an HH:MM:SS BCD counter chain.
// Generates the one-second advance enable, runs the two-button time-setting
// state machine, edits hour/minute BCD digits and pulses load to commit them.
module time_set_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic       cnt_en,
  output logic       load,
  output logic [3:0] set_hour1,
  output logic [3:0] set_hour0,
  output logic [3:0] set_min1,
  output logic [3:0] set_min0,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int            PW    = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_SET_HOUR = 2'b01,
    S_SET_MIN  = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_mode_prev;
  logic          r_inc_prev;
  logic          w_mode_press;
  logic          w_inc_press;
  logic [3:0]    r_set_hour1, r_set_hour0, r_set_min1, r_set_min0;
  logic [3:0]    w_hour1_inc, w_hour0_inc, w_min1_inc, w_min0_inc;
  logic [PW-1:0] r_presc;
  logic          r_cnt_en;
  logic          r_load;
  logic [PW-1:0] r_blink_cnt;
  logic          r_blink;

  // Rising-edge detect on both buttons. Previous levels reset high so a
  // button held through reset must be released before it counts as a press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its sources, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
    end else begin
      r_mode_prev <= btn_mode;
      r_inc_prev  <= btn_inc;
    end
  end

  assign w_mode_press = btn_mode & ~r_mode_prev;
  // Mode wins over a simultaneous increment.
  assign w_inc_press  = btn_inc & ~r_inc_prev & ~w_mode_press;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  // Next-state logic: mode press cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:      if (w_mode_press) w_next = S_SET_HOUR;
      S_SET_HOUR: if (w_mode_press) w_next = S_SET_MIN;
      S_SET_MIN:  if (w_mode_press) w_next = S_RUN;
      default:    w_next = S_RUN;
    endcase
  end

  // Outputs decoded from state; blink is forced low outside the set states.
  always_comb begin
    mode  = r_state;
    blink = r_blink & (r_state != S_RUN);
  end

  assign cnt_en    = r_cnt_en;
  assign load      = r_load;
  assign set_hour1 = r_set_hour1;
  assign set_hour0 = r_set_hour0;
  assign set_min1  = r_set_min1;
  assign set_min0  = r_set_min0;

  // BCD +1 for hours (23 wraps to 00) and minutes (59 wraps to 00).
  always_comb begin
    w_hour1_inc = r_set_hour1;
    w_hour0_inc = r_set_hour0 + 4'd1;
    if (r_set_hour1 == 4'd2 && r_set_hour0 == 4'd3) begin
      w_hour1_inc = 4'd0;
      w_hour0_inc = 4'd0;
    end else if (r_set_hour0 == 4'd9) begin
      w_hour1_inc = r_set_hour1 + 4'd1;
      w_hour0_inc = 4'd0;
    end
    w_min1_inc = r_set_min1;
    w_min0_inc = r_set_min0 + 4'd1;
    if (r_set_min0 == 4'd9) begin
      w_min0_inc = 4'd0;
      w_min1_inc = (r_set_min1 == 4'd5) ? 4'd0 : r_set_min1 + 4'd1;
    end
  end

  // Edit registers: capture current time on entry, step the digit pair being set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_hour1 <= 4'd0;
      r_set_hour0 <= 4'd0;
      r_set_min1  <= 4'd0;
      r_set_min0  <= 4'd0;
    end else if (r_state == S_RUN && w_mode_press) begin
      r_set_hour1 <= cur_hour1;
      r_set_hour0 <= cur_hour0;
      r_set_min1  <= cur_min1;
      r_set_min0  <= cur_min0;
    end else if (r_state == S_SET_HOUR && w_inc_press) begin
      r_set_hour1 <= w_hour1_inc;
      r_set_hour0 <= w_hour0_inc;
    end else if (r_state == S_SET_MIN && w_inc_press) begin
      r_set_min1  <= w_min1_inc;
      r_set_min0  <= w_min0_inc;
    end
  end

  // Load pulse for the cycle after leaving SET_MIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_load <= 1'b0;
    else     r_load <= (r_state == S_SET_MIN) && w_mode_press;
  end

  // One-second prescaler: runs only while staying in RUN, otherwise parked at
  // 0 so setting freezes time and RUN re-entry restarts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc  <= '0;
      r_cnt_en <= 1'b0;
    end else if (r_state == S_RUN && w_next == S_RUN) begin
      if (r_presc == P_TOP) begin
        r_presc  <= '0;
        r_cnt_en <= 1'b1;
      end else begin
        r_presc  <= r_presc + 1'b1;
        r_cnt_en <= 1'b0;
      end
    end else begin
      r_presc  <= '0;
      r_cnt_en <= 1'b0;
    end
  end

  // Blink divider: starts at 1 on SET_HOUR entry, toggles every TICK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_next == S_RUN) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == P_TOP) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

endmodule
